// File: rtl/inst_uj_dec_pipe.sv
`timescale 1ns/1ps
// Decoder for LUI / AUIPC / JAL with one-cycle latency: an output register plus a skid register.
// in_ready comes from the skid-valid flop only; saturating per-class counters count delivered bundles.
module inst_uj_dec_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_target,
    output logic             out_misaligned,
    output logic             out_illegal,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_u,
    output logic [CNT_W-1:0] cnt_j,
    output logic [CNT_W-1:0] cnt_ill
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef struct packed {
        logic [1:0]      kind;
        logic [4:0]      rd;
        logic            wen;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] target;
        logic            misaligned;
        logic            illegal;
    } bundle_t;

    bundle_t         dec;
    bundle_t         or_q;
    bundle_t         sk_q;
    logic            or_vld;
    logic            sk_vld;
    logic            acc;
    logic            fire;
    logic            or_load;
    logic signed [31:0] u_raw;
    logic signed [20:0] j_raw;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] jal_tgt;

    // Signed size casts carry the sign bit up to XLEN for either width.
    always_comb begin
        u_raw   = {in_instr[31:12], 12'b0};
        j_raw   = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        u_imm   = XLEN'(u_raw);
        j_imm   = XLEN'(j_raw);
        jal_tgt = in_pc + j_imm;
    end

    always_comb begin
        dec = '0;
        unique case (in_instr[6:0])
            OP_LUI: begin
                dec.kind   = 2'b01;
                dec.imm    = u_imm;
                dec.result = u_imm;
            end
            OP_AUIPC: begin
                dec.kind   = 2'b10;
                dec.imm    = u_imm;
                dec.result = in_pc + u_imm;
            end
            OP_JAL: begin
                dec.kind       = 2'b11;
                dec.imm        = j_imm;
                dec.result     = in_pc + XLEN'(4);
                dec.target     = jal_tgt;
                dec.misaligned = jal_tgt[1];
            end
            default: dec.illegal = 1'b1;
        endcase
        if (!dec.illegal) begin
            dec.rd  = in_instr[11:7];
            dec.wen = (in_instr[11:7] != 5'd0);
        end
    end

    assign in_ready = ~sk_vld;
    assign acc      = in_valid & ~sk_vld;
    assign fire     = or_vld & out_ready;
    assign or_load  = ~or_vld | fire;

    // The skid register always drains first so ordering stays FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_vld <= 1'b0;
            sk_vld <= 1'b0;
            or_q   <= '0;
            sk_q   <= '0;
        end else if (or_load) begin
            if (sk_vld) begin
                or_q   <= sk_q;
                or_vld <= 1'b1;
                sk_vld <= 1'b0;
            end else if (acc) begin
                or_q   <= dec;
                or_vld <= 1'b1;
            end else begin
                or_vld <= 1'b0;
            end
        end else if (acc) begin
            sk_q   <= dec;
            sk_vld <= 1'b1;
        end
    end

    assign out_valid      = or_vld;
    assign out_kind       = or_q.kind;
    assign out_rd         = or_q.rd;
    assign out_wen        = or_q.wen;
    assign out_imm        = or_q.imm;
    assign out_result     = or_q.result;
    assign out_target     = or_q.target;
    assign out_misaligned = or_q.misaligned;
    assign out_illegal    = or_q.illegal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_u   <= '0;
            cnt_j   <= '0;
            cnt_ill <= '0;
        end else if (cnt_clr) begin
            cnt_u   <= '0;
            cnt_j   <= '0;
            cnt_ill <= '0;
        end else if (fire) begin
            if (or_q.kind == 2'b01 || or_q.kind == 2'b10) cnt_u <= sat_inc(cnt_u);
            if (or_q.kind == 2'b11)                       cnt_j <= sat_inc(cnt_j);
            if (or_q.illegal)                             cnt_ill <= sat_inc(cnt_ill);
        end
    end

endmodule

// File: tb/tb_inst_uj_dec_pipe.sv
`timescale 1ns/1ps
// Bench for inst_uj_dec_pipe: a 32-bit/2-bit-counter and a 64-bit/16-bit-counter instance share stimulus.
// A queue-based reference model predicts occupancy, outputs and counters every cycle.
module tb_inst_uj_dec_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, out_ready, cnt_clr;
    logic [31:0] in_instr;
    logic [63:0] pc64;

    logic        a_in_ready, a_out_valid, a_wen, a_mis, a_ill;
    logic [1:0]  a_kind;
    logic [4:0]  a_rd;
    logic [31:0] a_imm, a_res, a_tgt;
    logic [1:0]  a_cu, a_cj, a_ci;

    logic        b_in_ready, b_out_valid, b_wen, b_mis, b_ill;
    logic [1:0]  b_kind;
    logic [4:0]  b_rd;
    logic [63:0] b_imm, b_res, b_tgt;
    logic [15:0] b_cu, b_cj, b_ci;

    always #5 clk = ~clk;

    inst_uj_dec_pipe #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(pc64[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_kind(a_kind), .out_rd(a_rd), .out_wen(a_wen), .out_imm(a_imm), .out_result(a_res),
        .out_target(a_tgt), .out_misaligned(a_mis), .out_illegal(a_ill), .cnt_clr(cnt_clr),
        .cnt_u(a_cu), .cnt_j(a_cj), .cnt_ill(a_ci));

    inst_uj_dec_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(pc64), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_kind(b_kind), .out_rd(b_rd), .out_wen(b_wen), .out_imm(b_imm), .out_result(b_res),
        .out_target(b_tgt), .out_misaligned(b_mis), .out_illegal(b_ill), .cnt_clr(cnt_clr),
        .cnt_u(b_cu), .cnt_j(b_cj), .cnt_ill(b_ci));

    typedef struct { logic [31:0] ins; logic [63:0] pc; } item_t;
    typedef struct packed {
        logic [1:0] kind; logic [4:0] rd; logic wen;
        logic [63:0] imm; logic [63:0] res; logic [63:0] tgt;
        logic mis; logic ill;
    } exp_t;

    item_t q[$];
    int    n_chk = 0, n_err = 0;
    int    c_u = 0, c_j = 0, c_ill = 0;
    bit    last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    // Reference decode written from the instruction-format rules using integer arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
        exp_t        e;
        int          ui, jv;
        logic [19:0] jf;
        e  = '0;
        ui = int'(ins & 32'hFFFFF000);
        jf = {ins[31], ins[19:12], ins[20], ins[30:21]};
        jv = int'(jf);
        if (jv >= (1 << 19)) jv = jv - (1 << 20);
        case (ins[6:0])
            7'h37: begin e.kind = 2'd1; e.imm = longint'(ui); e.res = e.imm; end
            7'h17: begin e.kind = 2'd2; e.imm = longint'(ui); e.res = pc + e.imm; end
            7'h6F: begin
                e.kind = 2'd3; e.imm = longint'(jv) * 2;
                e.res = pc + 64'd4; e.tgt = pc + e.imm; e.mis = e.tgt[1];
            end
            default: e.ill = 1'b1;
        endcase
        if (!e.ill) begin
            e.rd  = ins[11:7];
            e.wen = (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    // One clock: check at the falling edge, advance the model, return 1 ns after the rising edge.
    task automatic cycle();
        int   sz;
        bit   fire, acc;
        exp_t e;
        @(negedge clk);
        sz   = q.size();
        fire = (sz > 0) && out_ready;
        acc  = in_valid && (sz < 2);
        chk("a_out_valid", a_out_valid, sz > 0);
        chk("a_in_ready", a_in_ready, sz < 2);
        chk("b_out_valid", b_out_valid, sz > 0);
        chk("b_in_ready", b_in_ready, sz < 2);
        chk("a_cnt_u", a_cu, sat(c_u, 3));
        chk("a_cnt_j", a_cj, sat(c_j, 3));
        chk("a_cnt_ill", a_ci, sat(c_ill, 3));
        chk("b_cnt_u", b_cu, sat(c_u, 65535));
        chk("b_cnt_j", b_cj, sat(c_j, 65535));
        chk("b_cnt_ill", b_ci, sat(c_ill, 65535));
        if (sz > 0) begin
            e = model(q[0].ins, q[0].pc);
            chk("a_kind", a_kind, e.kind);
            chk("a_rd", a_rd, e.rd);
            chk("a_wen", a_wen, e.wen);
            chk("a_imm", a_imm, e.imm[31:0]);
            chk("a_result", a_res, e.res[31:0]);
            chk("a_target", a_tgt, e.tgt[31:0]);
            chk("a_misaligned", a_mis, e.mis);
            chk("a_illegal", a_ill, e.ill);
            chk("b_imm", b_imm, e.imm);
            chk("b_result", b_res, e.res);
            chk("b_target", b_tgt, e.tgt);
            chk("b_misaligned", b_mis, e.mis);
            chk("b_rd_kind", {b_kind, b_rd, b_wen, b_ill}, {e.kind, e.rd, e.wen, e.ill});
        end
        if (fire) begin
            e = model(q[0].ins, q[0].pc);
            void'(q.pop_front());
            if (e.kind == 2'd1 || e.kind == 2'd2) c_u++;
            if (e.kind == 2'd3) c_j++;
            if (e.ill) c_ill++;
        end
        if (cnt_clr) begin c_u = 0; c_j = 0; c_ill = 0; end
        if (acc) q.push_back('{ins: in_instr, pc: pc64});
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1; in_instr = ins; pc64 = pc;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        int base, sent, budget;
        logic [31:0] r;
        in_valid = 0; out_ready = 1; cnt_clr = 0; in_instr = 0; pc64 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_cnt", {a_cu, a_cj, a_ci}, 0);
        chk("rst_result", a_res, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cycle();

        send(32'h123452B7, 64'h0);
        chk("lui_valid", a_out_valid, 1);
        chk("lui_kind", a_kind, 2'b01);
        chk("lui_rd", a_rd, 5);
        chk("lui_imm", a_imm, 32'h12345000);
        chk("lui_result", a_res, 32'h12345000);
        chk("lui_wen", a_wen, 1);
        cycle();

        send(32'hFFFFF517, 64'h1000);
        chk("auipc_imm32", a_imm, 32'hFFFFF000);
        chk("auipc_res32", a_res, 32'h0);
        chk("auipc_rd", a_rd, 10);
        chk("auipc_imm64", b_imm, 64'hFFFFFFFFFFFFF000);
        chk("auipc_res64", b_res, 64'h0);
        cycle();

        send(32'h008000EF, 64'h100);
        chk("jal_kind", a_kind, 2'b11);
        chk("jal_rd", a_rd, 1);
        chk("jal_imm", a_imm, 32'h8);
        chk("jal_result", a_res, 32'h104);
        chk("jal_target", a_tgt, 32'h108);
        chk("jal_mis", a_mis, 0);
        cycle();

        send(32'h0020006F, 64'h0);
        chk("jal2_target", a_tgt, 32'h2);
        chk("jal2_mis", a_mis, 1);
        chk("jal2_wen", a_wen, 0);
        cycle();

        base = c_ill;
        send(32'h00000013, 64'h40);
        chk("ill_flag", a_ill, 1);
        chk("ill_kind", a_kind, 0);
        chk("ill_data", {a_imm, a_res, a_tgt, a_rd, a_wen}, 0);
        cycle();
        chk("ill_cnt", a_ci, sat(base + 1, 3));

        // Backpressure: two accepts fill OR and SK, third word waits.
        out_ready = 0; in_valid = 1;
        in_instr = 32'hAAAAA0B7; pc64 = 0; cycle();
        in_instr = 32'hBBBBB137; cycle();
        chk("bp_in_ready_low", a_in_ready, 0);
        in_instr = 32'hCCCCC1B7; cycle();
        cycle();
        chk("bp_held_out", a_res, 32'hAAAAA000);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_consec_vld", a_out_valid, 1);
            cycle();
            if (i == 1) in_valid = 0;
        end
        cycle();

        // Counter saturation on the 2-bit instance, then clear racing a fire.
        cnt_clr = 1; cycle(); cnt_clr = 0;
        in_valid = 1; in_instr = 32'h000012B7; pc64 = 0;
        repeat (5) cycle();
        in_valid = 0;
        repeat (2) cycle();
        chk("sat_cnt_u", a_cu, 3);
        chk("sat_cnt_u64", b_cu, 5);
        send(32'h000012B7, 64'h0);
        cnt_clr = 1; cycle(); cnt_clr = 0;
        chk("clr_fire_u", a_cu, 0);
        chk("clr_fire_u64", b_cu, 0);

        // Random traffic with random backpressure.
        sent = 0; budget = 0;
        in_valid = 0;
        while (sent < 1000 && budget < 20000) begin
            if (!in_valid || last_acc) begin
                r = $urandom;
                case ($urandom_range(0, 3))
                    0: r[6:0] = 7'h37;
                    1: r[6:0] = 7'h17;
                    2: r[6:0] = 7'h6F;
                    default: ;
                endcase
                in_instr = r;
                pc64 = {$urandom, $urandom};
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr = ($urandom_range(0, 49) == 0);
            cycle();
            if (last_acc) sent++;
            budget++;
        end
        chk("rand_words_sent", sent, 1000);
        in_valid = 0; cnt_clr = 0; out_ready = 1;
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
        cycle();
        chk("drain_out_valid", a_out_valid, 0);

        // Asynchronous reset with both registers full.
        out_ready = 0; in_valid = 1; in_instr = 32'h00000337;
        cycle(); cycle();
        in_valid = 0;
        chk("pre_rst_in_ready", a_in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", a_out_valid, 0);
        chk("arst_in_ready", a_in_ready, 1);
        chk("arst_cnt", {a_cu, a_cj, a_ci}, 0);
        chk("arst_cnt64", {b_cu, b_cj, b_ci}, 0);
        chk("arst_out_valid64", b_out_valid, 0);
        q.delete(); c_u = 0; c_j = 0; c_ill = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1;
        send(32'hFFFFF517, 64'h1000);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
